// File: rtl/ttc_bx_tracker_pkg.sv
// Shared definitions for the TTC bunch/orbit tracker: sync state encoding and LHC defaults.
package ttc_bx_tracker_pkg;

  typedef enum logic [1:0] {
    ST_HOLD   = 2'd0,
    ST_ACQ    = 2'd1,
    ST_LOCKED = 2'd2,
    ST_LOST   = 2'd3
  } sync_state_t;

  localparam int LHC_CYCLE_DEF = 3564;

endpackage

// File: rtl/ttc_bx_tracker_if.sv
// TTC decoder / trigger-DAQ side bundle for the bunch/orbit tracker.
interface ttc_bx_tracker_if #(
  parameter int MXBXN = 12,
  parameter int MXORB = 32,
  parameter int MXERR = 16
);
  import ttc_bx_tracker_pkg::*;

  logic             ttc_bx0;
  logic             ttc_resync;
  logic             ttc_l1a;
  logic [MXBXN-1:0] bxn_offset;
  logic [MXBXN-1:0] bxn_counter;
  logic [MXORB-1:0] orbit_counter;
  sync_state_t      sync_state;
  logic             locked;
  logic [MXERR-1:0] bx0_err_cnt;
  logic [MXERR-1:0] unlock_cnt;
  logic             l1a_valid;
  logic [MXBXN-1:0] l1a_bxn;
  logic [MXORB-1:0] l1a_orbit;
  logic             l1a_unlocked;

  modport master (
    output ttc_bx0, ttc_resync, ttc_l1a, bxn_offset,
    input  bxn_counter, orbit_counter, sync_state, locked, bx0_err_cnt, unlock_cnt,
    input  l1a_valid, l1a_bxn, l1a_orbit, l1a_unlocked
  );

  modport slave (
    input  ttc_bx0, ttc_resync, ttc_l1a, bxn_offset,
    output bxn_counter, orbit_counter, sync_state, locked, bx0_err_cnt, unlock_cnt,
    output l1a_valid, l1a_bxn, l1a_orbit, l1a_unlocked
  );

endinterface

// File: rtl/ttc_bx_tracker_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clock) begin
    if (reset || clr)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + WIDTH'(1);
  end

endmodule

// File: rtl/ttc_bx_tracker.sv
// Bunch/orbit tracker: bxn/orbit counting, bx0 lock/unlock hysteresis, misalignment counting, L1A latching.
module ttc_bx_tracker
  import ttc_bx_tracker_pkg::*;
#(
  parameter int MXBXN      = 12,
  parameter int LHC_CYCLE  = LHC_CYCLE_DEF,
  parameter int MXORB      = 32,
  parameter int MXERR      = 16,
  parameter int LOCK_GOOD  = 4,
  parameter int UNLOCK_BAD = 2
) (
  input logic clock,
  input logic reset,
  ttc_bx_tracker_if.slave bus
);

  localparam logic [MXBXN-1:0] LAST_BX = MXBXN'(LHC_CYCLE - 1);
  localparam int GW = $clog2(LOCK_GOOD + 1);
  localparam int BW = $clog2(UNLOCK_BAD + 1);
  localparam logic [GW-1:0] GOOD_TGT = GW'(LOCK_GOOD);
  localparam logic [BW-1:0] BAD_TGT  = BW'(UNLOCK_BAD);

  sync_state_t      state;
  logic [GW-1:0]    good_run;
  logic [BW-1:0]    bad_run;
  logic [MXBXN-1:0] off_lim_p1;
  logic [MXBXN-1:0] bxn;
  logic [MXBXN-1:0] realign_bx;
  logic             align, good, bad, realign;
  logic             err_inc, unlock_inc, orbit_inc;

  // Stage p1: clamp the offset into the orbit range
  always_ff @(posedge clock) begin
    if (reset)
      off_lim_p1 <= '0;
    else
      off_lim_p1 <= (bus.bxn_offset > LAST_BX) ? LAST_BX : bus.bxn_offset;
  end

  assign align      = (bxn == off_lim_p1);
  assign good       = bus.ttc_bx0 && align;
  assign bad        = bus.ttc_bx0 ^ align;
  assign realign_bx = (off_lim_p1 == LAST_BX) ? '0 : off_lim_p1 + MXBXN'(1);

  // Only HOLD, LOST and a misaligned bx0 in ACQ move the phase; LOCKED flywheels
  assign realign = !bus.ttc_resync && bus.ttc_bx0 &&
                   ((state == ST_HOLD) || (state == ST_LOST) || ((state == ST_ACQ) && !align));

  assign err_inc    = !bus.ttc_resync && bad && (state != ST_HOLD);
  assign unlock_inc = !bus.ttc_resync && bad && (state == ST_LOCKED) &&
                      (bad_run + BW'(1) == BAD_TGT);
  assign orbit_inc  = !bus.ttc_resync && (state != ST_HOLD) && (bxn == LAST_BX);

  always_ff @(posedge clock) begin
    if (reset)
      bxn <= '0;
    else if (bus.ttc_resync || (state == ST_HOLD && !realign))
      bxn <= off_lim_p1;
    else if (realign)
      bxn <= realign_bx;
    else
      bxn <= (bxn == LAST_BX) ? '0 : bxn + MXBXN'(1);
  end

  always_ff @(posedge clock) begin
    if (reset || bus.ttc_resync) begin
      state    <= ST_HOLD;
      good_run <= '0;
      bad_run  <= '0;
    end else begin
      case (state)
        ST_HOLD, ST_LOST: begin
          if (bus.ttc_bx0) begin
            state    <= (LOCK_GOOD == 1) ? ST_LOCKED : ST_ACQ;
            good_run <= GW'(1);
            bad_run  <= '0;
          end
        end
        ST_ACQ: begin
          if (good) begin
            good_run <= good_run + GW'(1);
            if (good_run + GW'(1) == GOOD_TGT) begin
              state   <= ST_LOCKED;
              bad_run <= '0;
            end
          end else if (bus.ttc_bx0) begin
            good_run <= GW'(1);
            if (LOCK_GOOD == 1) state <= ST_LOCKED;
          end else if (align) begin
            good_run <= '0;
          end
        end
        ST_LOCKED: begin
          if (good) begin
            bad_run <= '0;
          end else if (bad) begin
            if (bad_run + BW'(1) == BAD_TGT) begin
              state   <= ST_LOST;
              bad_run <= '0;
            end else begin
              bad_run <= bad_run + BW'(1);
            end
          end
        end
        default: state <= ST_HOLD;
      endcase
    end
  end

  sat_counter #(.WIDTH(MXERR)) u_err_cnt (
    .clock(clock), .reset(reset), .clr(1'b0), .inc(err_inc), .count(bus.bx0_err_cnt)
  );

  sat_counter #(.WIDTH(MXERR)) u_unlock_cnt (
    .clock(clock), .reset(reset), .clr(1'b0), .inc(unlock_inc), .count(bus.unlock_cnt)
  );

  sat_counter #(.WIDTH(MXORB)) u_orbit_cnt (
    .clock(clock), .reset(reset), .clr(bus.ttc_resync), .inc(orbit_inc), .count(bus.orbit_counter)
  );

  // Stage p1: event header latch, sees pre-resync counter values
  always_ff @(posedge clock) begin
    if (reset) begin
      bus.l1a_valid    <= 1'b0;
      bus.l1a_bxn      <= '0;
      bus.l1a_orbit    <= '0;
      bus.l1a_unlocked <= 1'b0;
    end else begin
      bus.l1a_valid <= bus.ttc_l1a;
      if (bus.ttc_l1a) begin
        bus.l1a_bxn      <= bxn;
        bus.l1a_orbit    <= bus.orbit_counter;
        bus.l1a_unlocked <= (state != ST_LOCKED);
      end
    end
  end

  assign bus.bxn_counter = bxn;
  assign bus.sync_state  = state;
  assign bus.locked      = (state == ST_LOCKED);

endmodule

// File: tb/tb_ttc_bx_tracker.sv
// Directed bench for ttc_bx_tracker: lock acquisition, loss, offset clamp, resync, L1A latching, saturation.
module tb_ttc_bx_tracker;
  import ttc_bx_tracker_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clock = ~clock;

  ttc_bx_tracker_if bus ();
  ttc_bx_tracker_if #(.MXBXN(4), .MXORB(2), .MXERR(2)) sb ();

  ttc_bx_tracker dut (.clock(clock), .reset(reset), .bus(bus));

  // Narrow instance so the saturation limits are reachable in a few cycles
  ttc_bx_tracker #(
    .MXBXN(4), .LHC_CYCLE(8), .MXORB(2), .MXERR(2), .LOCK_GOOD(1), .UNLOCK_BAD(1)
  ) dut_small (.clock(clock), .reset(reset), .bus(sb));

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_bxn(input int v);
    int n = 0;
    while (bus.bxn_counter != 12'(v) && n < 4000) begin
      step();
      n++;
    end
    tests++;
    assert (n < 4000)
    else begin
      fails++;
      $error("FAIL wait_bxn_%0d: waited %0d cycles, required fewer than 4000", v, n);
    end
  endtask

  task automatic pulse_bx0();
    bus.ttc_bx0 = 1'b1;
    step();
    bus.ttc_bx0 = 1'b0;
  endtask

  initial begin
    bus.ttc_bx0 = 0; bus.ttc_resync = 0; bus.ttc_l1a = 0; bus.bxn_offset = '0;
    sb.ttc_bx0 = 0; sb.ttc_resync = 0; sb.ttc_l1a = 0; sb.bxn_offset = '0;
    repeat (3) step();
    reset = 1'b0;

    // Reset state
    check("rst_state", bus.sync_state, 0);
    check("rst_bxn", bus.bxn_counter, 0);
    check("rst_orbit", bus.orbit_counter, 0);
    check("rst_err", bus.bx0_err_cnt, 0);
    check("rst_l1a_valid", bus.l1a_valid, 0);
    check("rst_locked", bus.locked, 0);
    repeat (2) step();

    // Lock acquisition with offset 0
    pulse_bx0();
    check("acq_state", bus.sync_state, 1);
    check("acq_bxn", bus.bxn_counter, 1);
    check("acq_orbit", bus.orbit_counter, 0);
    for (int i = 0; i < 3; i++) begin
      wait_bxn(0);
      pulse_bx0();
    end
    check("lock_state", bus.sync_state, 2);
    check("lock_locked", bus.locked, 1);
    check("lock_err", bus.bx0_err_cnt, 0);
    check("lock_orbit", bus.orbit_counter, 3);
    for (int i = 0; i < 4; i++) begin
      wait_bxn(0);
      pulse_bx0();
    end
    check("orbit7", bus.orbit_counter, 7);

    // Early bx0 while locked: one bad check, still locked
    wait_bxn(5);
    pulse_bx0();
    check("early_err", bus.bx0_err_cnt, 1);
    check("early_state", bus.sync_state, 2);

    // L1A while locked
    wait_bxn(100);
    bus.ttc_l1a = 1'b1;
    step();
    bus.ttc_l1a = 1'b0;
    check("l1a_valid", bus.l1a_valid, 1);
    check("l1a_bxn", bus.l1a_bxn, 100);
    check("l1a_orbit", bus.l1a_orbit, 7);
    check("l1a_unlocked", bus.l1a_unlocked, 0);
    step();
    check("l1a_pulse_end", bus.l1a_valid, 0);
    check("l1a_bxn_hold", bus.l1a_bxn, 100);

    // Back-to-back L1A
    wait_bxn(200);
    bus.ttc_l1a = 1'b1;
    step();
    check("b2b_valid0", bus.l1a_valid, 1);
    check("b2b_bxn0", bus.l1a_bxn, 200);
    step();
    bus.ttc_l1a = 1'b0;
    check("b2b_valid1", bus.l1a_valid, 1);
    check("b2b_bxn1", bus.l1a_bxn, 201);

    // Missing bx0 at the expected slot: second bad check unlocks
    wait_bxn(0);
    step();
    check("lost_state", bus.sync_state, 3);
    check("lost_err", bus.bx0_err_cnt, 2);
    check("lost_unlock", bus.unlock_cnt, 1);
    check("lost_locked", bus.locked, 0);
    bus.ttc_l1a = 1'b1;
    step();
    bus.ttc_l1a = 1'b0;
    check("lost_l1a_unlocked", bus.l1a_unlocked, 1);
    check("lost_l1a_bxn", bus.l1a_bxn, 1);
    check("lost_l1a_orbit", bus.l1a_orbit, 8);

    // Misaligned bx0 in LOST: counted, realigns, back to ACQ
    wait_bxn(10);
    pulse_bx0();
    check("relock_state", bus.sync_state, 1);
    check("relock_bxn", bus.bxn_counter, 1);
    check("relock_err", bus.bx0_err_cnt, 3);
    for (int i = 0; i < 3; i++) begin
      wait_bxn(0);
      pulse_bx0();
    end
    check("relock_locked", bus.sync_state, 2);
    check("relock_orbit", bus.orbit_counter, 11);

    // Resync + bx0 + L1A in the same cycle while locked
    wait_bxn(50);
    bus.ttc_resync = 1'b1; bus.ttc_bx0 = 1'b1; bus.ttc_l1a = 1'b1;
    step();
    bus.ttc_resync = 1'b0; bus.ttc_bx0 = 1'b0; bus.ttc_l1a = 1'b0;
    check("rsy_state", bus.sync_state, 0);
    check("rsy_orbit", bus.orbit_counter, 0);
    check("rsy_bxn", bus.bxn_counter, 0);
    check("rsy_err", bus.bx0_err_cnt, 3);
    check("rsy_unlock", bus.unlock_cnt, 1);
    check("rsy_l1a_bxn", bus.l1a_bxn, 50);
    check("rsy_l1a_orbit", bus.l1a_orbit, 11);
    check("rsy_l1a_unlocked", bus.l1a_unlocked, 0);

    // Out-of-range offset clamps to the last BX
    bus.bxn_offset = 12'd4000;
    repeat (3) step();
    check("clamp_bxn", bus.bxn_counter, 3563);
    check("clamp_state", bus.sync_state, 0);
    pulse_bx0();
    check("clamp_realign_bxn", bus.bxn_counter, 0);
    check("clamp_realign_orbit", bus.orbit_counter, 0);
    check("clamp_realign_state", bus.sync_state, 1);
    check("clamp_hold_no_err", bus.bx0_err_cnt, 3);
    wait_bxn(3563);
    step();
    check("clamp_wrap_orbit", bus.orbit_counter, 1);
    check("clamp_wrap_bxn", bus.bxn_counter, 0);
    check("clamp_missing_err", bus.bx0_err_cnt, 4);

    // Saturation on the narrow instance
    sb.ttc_bx0 = 1'b1;
    step();
    sb.ttc_bx0 = 1'b0;
    check("sat_lock", sb.sync_state, 2);
    repeat (64) step();
    check("sat_err", sb.bx0_err_cnt, 3);
    check("sat_orbit", sb.orbit_counter, 3);
    check("sat_unlock", sb.unlock_cnt, 1);
    check("sat_state", sb.sync_state, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
